// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (IF) and data memory (DM) ports.
// Optional wait-cycle performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cycles,
    output logic [31:0]       dm_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] C_STARVE_MAX   = 8'(STARVE_MAX);
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_owner_dm;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        r_wait_cnt;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic              r_err;
    logic              r_busy;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_be;

    logic              w_grant_if;
    logic              w_grant_dm;

    // DM has priority unless IF has lost STARVE_MAX arbitrations in a row
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (if_req && (!dm_req || (r_starve_cnt == C_STARVE_MAX))) begin
            w_grant_if = 1'b1;
        end else if (dm_req) begin
            w_grant_dm = 1'b1;
        end else begin
            w_grant_if = 1'b0;
            w_grant_dm = 1'b0;
        end
    end

    // Transaction sequencer with registered memory command, acks and read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_owner_dm   <= 1'b0;
            r_starve_cnt <= 8'd0;
            r_wait_cnt   <= 8'd0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_if_rdata   <= {DATA_W{1'b0}};
            r_dm_rdata   <= {DATA_W{1'b0}};
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_wdata  <= {DATA_W{1'b0}};
            r_mem_be     <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if || w_grant_dm) begin
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_owner_dm <= w_grant_dm;
                        if (w_grant_dm) begin
                            r_mem_we    <= dm_we;
                            r_mem_addr  <= dm_addr;
                            r_mem_wdata <= dm_wdata;
                            r_mem_be    <= dm_be;
                            if (if_req && (r_starve_cnt < C_STARVE_MAX)) begin
                                r_starve_cnt <= r_starve_cnt + 8'd1;
                            end
                        end else begin
                            r_mem_we     <= 1'b0;
                            r_mem_addr   <= if_addr;
                            r_mem_wdata  <= {DATA_W{1'b0}};
                            r_mem_be     <= 4'hF;
                            r_starve_cnt <= 8'd0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt) begin
                        r_state    <= S_WAIT;
                        r_mem_req  <= 1'b0;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state  <= S_RESP;
                        r_err    <= 1'b0;
                        r_if_ack <= !r_owner_dm;
                        r_dm_ack <= r_owner_dm;
                        if (r_owner_dm) begin
                            r_dm_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                    end else if (r_wait_cnt == C_TIMEOUT_LAST) begin
                        r_state  <= S_RESP;
                        r_err    <= 1'b1;
                        r_if_ack <= !r_owner_dm;
                        r_dm_ack <= r_owner_dm;
                        if (r_owner_dm) begin
                            r_dm_rdata <= {DATA_W{1'b0}};
                        end else begin
                            r_if_rdata <= {DATA_W{1'b0}};
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_err    <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_if_ack  <= 1'b0;
                    r_dm_ack  <= 1'b0;
                    r_err     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ack    = r_dm_ack;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign busy      = r_busy;
    assign err       = r_err;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_if_wait_cycles;
    logic [31:0] r_dm_wait_cycles;

    // Saturating count of cycles each requester spends stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_if_wait_cycles <= 32'd0;
            r_dm_wait_cycles <= 32'd0;
        end else begin
            if (if_req && !r_if_ack && (r_if_wait_cycles != 32'hFFFF_FFFF)) begin
                r_if_wait_cycles <= r_if_wait_cycles + 32'd1;
            end
            if (dm_req && !r_dm_ack && (r_dm_wait_cycles != 32'hFFFF_FFFF)) begin
                r_dm_wait_cycles <= r_dm_wait_cycles + 32'd1;
            end
        end
    end

    assign if_wait_cycles = r_if_wait_cycles;
    assign dm_wait_cycles = r_dm_wait_cycles;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: fetch, delayed-grant store,
// priority, starvation, timeout with late response, and reset during WAIT.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [11:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_wait_cycles;
    logic [31:0] dm_wait_cycles;
`endif

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter #(
        .ADDR_W(12), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(255)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
`ifdef MEM_ARB_PERF_EN
        , .if_wait_cycles(if_wait_cycles), .dm_wait_cycles(dm_wait_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Wait for a command, grant it at once, respond next cycle; returns in the ack cycle
    task automatic do_xact(input logic [31:0] rd, output logic [11:0] a);
        int n;
        n = 0;
        a = 12'h000;
        while (n < 20 && mem_req !== 1'b1) begin
            step();
            n++;
        end
        chk("xact_mem_req_seen", {63'd0, mem_req}, 64'd1);
        a = mem_addr;
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] a;
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 12'h000;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 12'h000; dm_wdata = 32'h0; dm_be = 4'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_acks_err", {61'd0, if_ack, dm_ack, err}, 64'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        chk("rst_mem_fields", {15'd0, mem_we, mem_addr, mem_wdata, mem_be}, 64'd0);
        reset_n = 1'b1;
        step();

        // Single fetch: ack in cycle 3
        if_req = 1'b1; if_addr = 12'h010;
        step();
        chk("f_c1_mem_req", {63'd0, mem_req}, 64'd1);
        chk("f_c1_fields", {47'd0, mem_we, mem_addr, mem_be}, {47'd0, 1'b0, 12'h010, 4'hF});
        chk("f_c1_busy", {63'd0, busy}, 64'd1);
        mem_gnt = 1'b1;
        step();
        chk("f_c2_mem_req", {63'd0, mem_req}, 64'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        step();
        chk("f_c3_acks", {62'd0, if_ack, dm_ack}, 64'd2);
        chk("f_c3_rdata", {32'd0, if_rdata}, 64'h13);
        chk("f_c3_err", {63'd0, err}, 64'd0);
        if_req = 1'b0; mem_rvalid = 1'b0;
        step();
        chk("f_c4_idle", {62'd0, if_ack, busy}, 64'd0);

        // Store with grant 3 cycles late: fields constant over 4 ISSUE cycles, ack in cycle 6
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("s_issue_fields", {14'd0, mem_req, mem_we, mem_addr, mem_wdata, mem_be},
                {14'd0, 1'b1, 1'b1, 12'h100, 32'hDEAD_BEEF, 4'h3});
        end
        mem_gnt = 1'b1;
        step();
        chk("s_c5_no_ack", {62'd0, if_ack, dm_ack}, 64'd0);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00A5;
        step();
        chk("s_c6_acks", {61'd0, if_ack, dm_ack, err}, 64'd2);
        chk("s_c6_dm_rdata", {32'd0, dm_rdata}, 64'hA5);
        dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
        step();

        // Priority: simultaneous requests, DM first then IF
        if_req = 1'b1; if_addr = 12'h020;
        dm_req = 1'b1; dm_addr = 12'h200; dm_be = 4'hF;
        do_xact(32'h0000_0111, a);
        chk("p_first_addr", {52'd0, a}, 64'h200);
        chk("p_first_acks", {62'd0, if_ack, dm_ack}, 64'd1);
        chk("p_dm_rdata", {32'd0, dm_rdata}, 64'h111);
        dm_req = 1'b0;
        do_xact(32'h0000_0222, a);
        chk("p_second_addr", {52'd0, a}, 64'h020);
        chk("p_second_acks", {62'd0, if_ack, dm_ack}, 64'd2);
        chk("p_if_rdata", {32'd0, if_rdata}, 64'h222);
        if_req = 1'b0;
        step();

        // Starvation: 4 DM wins, IF forced through on the 5th arbitration
        if_req = 1'b1; if_addr = 12'h030;
        dm_req = 1'b1; dm_addr = 12'h300;
        for (int k = 1; k <= 4; k++) begin
            do_xact(32'(k), a);
            chk("st_dm_addr", {52'd0, a}, 64'h300);
            chk("st_dm_ack", {62'd0, if_ack, dm_ack}, 64'd1);
            chk("st_cnt", {56'd0, dut.r_starve_cnt}, 64'(k));
        end
        do_xact(32'h0000_0005, a);
        chk("st_if_addr", {52'd0, a}, 64'h030);
        chk("st_if_ack", {62'd0, if_ack, dm_ack}, 64'd2);
        chk("st_cnt_clear", {56'd0, dut.r_starve_cnt}, 64'd0);
        if_req = 1'b0; dm_req = 1'b0;
        step();

        // Timeout: ack with err exactly 255 cycles after entering WAIT
        if_req = 1'b1; if_addr = 12'h040;
        step();
        chk("to_issue", {63'd0, mem_req}, 64'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 1; i <= 254; i++) step();
        chk("to_no_early_ack", {62'd0, if_ack, err}, 64'd0);
        step();
        chk("to_ack_err", {61'd0, if_ack, dm_ack, err}, 64'd5);
        chk("to_rdata_zero", {32'd0, if_rdata}, 64'd0);
        if_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_DEAD;
        step();
        chk("to_late_ignored", {61'd0, if_ack, err, busy}, 64'd0);
        chk("to_late_rdata", {32'd0, if_rdata}, 64'd0);
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 12'h044;
        do_xact(32'h0000_0077, a);
        chk("to_next_ok", {61'd0, if_ack, dm_ack, err}, 64'd4);
        chk("to_next_rdata", {32'd0, if_rdata}, 64'h77);
        if_req = 1'b0;
        step();

        // Reset during WAIT: immediate zeroing, no ack, reissue completes
        dm_req = 1'b1; dm_addr = 12'h400;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
        chk("rw_in_wait", {62'd0, busy, mem_req}, 64'd2);
        reset_n = 1'b0;
        dm_req = 1'b0;
        #1;
        chk("rw_outputs_zero", {58'd0, busy, mem_req, mem_we, if_ack, dm_ack, err}, 64'd0);
        chk("rw_rdata_zero", {if_rdata, dm_rdata}, 64'd0);
        chk("rw_mem_fields", {12'd0, mem_addr, mem_wdata, mem_be}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rw_no_ack", {61'd0, if_ack, dm_ack, busy}, 64'd0);
        dm_req = 1'b1;
        do_xact(32'h0000_0099, a);
        chk("rw_reissue_addr", {52'd0, a}, 64'h400);
        chk("rw_reissue_ack", {61'd0, if_ack, dm_ack, err}, 64'd2);
        chk("rw_reissue_rdata", {32'd0, dm_rdata}, 64'h99);
        dm_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
